decim_readout_arbiter: RTL and testbench
========================================

# decim_readout_arbiter

Multi-channel readout scheduler that sits after the per-channel decimators. Each decimator emits a 27-bit sample with a one-cycle valid pulse once per decimation period. This block captures each sample into a per-channel holding register and shares a single valid/ready output stream among the channels using round-robin arbitration. It tags every sample with a channel index and a per-channel sequence number, and flags samples dropped because downstream back-pressure kept a holding register full.

## Interface
- NCH, 4: number of decimator channels; power of two, ≥2; CW = log2(NCH)
- DW, 27: sample width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- en  in  1  capture enable; when low, in_valid is ignored and draining continues
- in_data  in  NCH*DW  channel i occupies bits [i*DW +: DW]
- in_valid  in  NCH  one-cycle new-sample pulse per channel (decimator new_data)
- out_data  out  DW  granted sample
- out_ch  out  CW  channel index of out_data
- out_seq  out  8  sequence number of out_data within its channel
- out_valid  out  1  output stage holds a sample
- out_ready  in  1  downstream accepts when out_valid & out_ready
- overflow  out  NCH  sticky per-channel drop flag
- ovf_clr  in  1  one-cycle pulse; clears all overflow bits

## Operation
- Per channel i: holding register hold_data[i] (DW), hold_seq[i] (8), full[i]; seq counter seq_cnt[i] (8).
- Capture event cap[i] = en & in_valid[i].
- On cap[i], seq_cnt[i] increments, modulo 256. It increments whether or not the sample is stored.
- Store rule for cap[i]:
  - If !full[i], or channel i is granted this cycle: load hold_data[i] = in_data slice and hold_seq[i] = seq_cnt[i] (pre-increment value); full[i] = 1.
  - Else (full and not granted): drop the new sample, keep the old contents, set overflow[i].
- Output stage has two states: EMPTY (out_valid=0) and HOLD (out_valid=1).
- Output is free when state = EMPTY, or HOLD & out_ready.
- Grant: when the output is free and any full[i]=1, select one channel by round-robin.
  - The output register loads hold_data/hold_seq/index of that channel.
  - full[granted] clears, unless cap[granted] reloads it the same cycle.
  - State becomes HOLD.
- Output free and no full channel: HOLD→EMPTY (if out_ready), otherwise stay EMPTY.
- Round-robin: pointer rr (CW bits). Search order is rr, rr+1, …, wrapping mod NCH. After a grant of channel k, rr = k+1 mod NCH. rr is unchanged when there is no grant.
- overflow bits are sticky. ovf_clr clears all bits. If ovf_clr and a drop event occur in the same cycle, that bit ends set (set wins).
- en low does not stop grants or clear full flags.

## Timing
- Reset (rst_n=0 at a clock edge) takes effect at that edge:
  - out_valid=0, out_data=0, out_ch=0, out_seq=0, overflow=0.
  - All full=0, seq_cnt=0, hold regs=0, rr=0, state EMPTY.
- Reset mid-transfer discards pending samples without handshake.
- Latency: cap[i] at edge t sets full[i] after t. If the output is free at edge t+1, out_valid=1 after t+1. Minimum 2 cycles from in_valid to out_valid.
- Throughput: one sample per cycle while out_ready=1 and samples are pending.
- While out_valid & !out_ready: out_data, out_ch and out_seq hold stable; no grant occurs.
- Same-cycle pop and push on a channel is lossless: the granted old sample goes out and the new sample is stored.
- Simultaneous captures on all channels in one cycle: all are stored. Grants then follow rr order on consecutive cycles.
- seq_cnt wraps 255→0 with no flag.

## Test plan
- Single sample: reset, en=1, out_ready=1, in_valid=4'b0001, in_data ch0=27'h123_4567 at cycle 0 → out_valid=1 at cycle 2 with out_data=27'h1234567, out_ch=0, out_seq=0. out_valid drops at cycle 3.
- Round-robin fairness: in_valid=4'b1111 with ch i data = i+1, out_ready=1, rr=0 → out_ch sequence 0,1,2,3 on cycles 2–5. A second burst then starts at ch0 (rr=0 after grant 3).
- Back-pressure and overflow: out_ready=0. Pulse ch2 three times, 512 cycles apart, data A, B, C.
  - out_data stays A (seq 0) and overflow=4'b0100.
  - Raise out_ready → only A then B (seq 1) are delivered. C is dropped and seq_cnt[2]=3.
- Same-cycle pop/push: ch1 full and granted in the same cycle as a new in_valid[1] → old sample is output, new sample is retained (full[1]=1), overflow[1]=0.
- ovf_clr vs drop: assert ovf_clr in the same cycle as a ch3 drop → overflow[3]=1. A clean ovf_clr later → overflow=0.
- Reset and enable: assert rst_n=0 while out_valid=1 and two channels are full → after one edge all outputs and flags are 0. With en=0, in_valid pulses produce no output and seq_cnt stays 0.

Source files
------------

// File: rtl/decim_readout_arbiter.sv
// Round-robin readout of per-channel decimator samples onto one valid/ready stream.
// Each channel holds one sample; new samples arriving while full (and not being popped) are dropped.

module decim_readout_lane #(
    parameter int DW = 27
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap,
    input  logic          grant,
    input  logic          ovf_clr,
    input  logic [DW-1:0] data,
    output logic [DW-1:0] hold_data,
    output logic [7:0]    hold_seq,
    output logic          full,
    output logic          overflow
);
    logic [7:0] seq_cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            seq_cnt   <= '0;
            hold_data <= '0;
            hold_seq  <= '0;
            full      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            if (cap) seq_cnt <= seq_cnt + 8'd1;
            // A grant frees the slot this edge, so a coincident capture is still stored.
            if (cap && (!full || grant)) begin
                hold_data <= data;
                hold_seq  <= seq_cnt;
                full      <= 1'b1;
            end else if (grant) begin
                full <= 1'b0;
            end
            if (cap && full && !grant) overflow <= 1'b1;
            else if (ovf_clr)          overflow <= 1'b0;
        end
    end
endmodule

module decim_readout_arbiter #(
    parameter  int NCH = 4,
    parameter  int DW  = 27,
    localparam int CW  = $clog2(NCH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic [NCH*DW-1:0] in_data,
    input  logic [NCH-1:0]    in_valid,
    output logic [DW-1:0]     out_data,
    output logic [CW-1:0]     out_ch,
    output logic [7:0]        out_seq,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [NCH-1:0]    overflow,
    input  logic              ovf_clr
);
    typedef enum logic {EMPTY, HOLD} state_t;

    state_t                   state, state_next;
    logic [NCH-1:0]           cap, grant, full;
    logic [NCH-1:0][DW-1:0]   hold_data;
    logic [NCH-1:0][7:0]      hold_seq;
    logic [CW-1:0]            rr, gnt_idx;
    logic                     gnt_any, free;

    assign cap = en ? in_valid : '0;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign grant[i] = free && gnt_any && (gnt_idx == CW'(i));

        decim_readout_lane #(.DW(DW)) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .cap       (cap[i]),
            .grant     (grant[i]),
            .ovf_clr   (ovf_clr),
            .data      (in_data[i*DW +: DW]),
            .hold_data (hold_data[i]),
            .hold_seq  (hold_seq[i]),
            .full      (full[i]),
            .overflow  (overflow[i])
        );
    end

    // Scan from the far end so the candidate closest to rr is the one that sticks.
    always_comb begin
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int j = NCH - 1; j >= 0; j--) begin
            if (full[rr + CW'(j)]) begin
                gnt_any = 1'b1;
                gnt_idx = rr + CW'(j);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= EMPTY;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (free) state_next = gnt_any ? HOLD : EMPTY;
    end

    always_comb begin
        out_valid = (state == HOLD);
        free      = (state == EMPTY) || out_ready;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data <= '0;
            out_ch   <= '0;
            out_seq  <= '0;
            rr       <= '0;
        end else if (free && gnt_any) begin
            out_data <= hold_data[gnt_idx];
            out_ch   <= gnt_idx;
            out_seq  <= hold_seq[gnt_idx];
            rr       <= gnt_idx + 1'b1;
        end
    end
endmodule

// File: tb/tb_decim_readout_arbiter.sv
// Directed plus randomized bench for decim_readout_arbiter against a per-cycle
// pop-then-push reference model of the channel slots and output register.

module tb_decim_readout_arbiter;
    localparam int NCH = 4;
    localparam int DW  = 27;
    localparam int CW  = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic [NCH*DW-1:0] in_data = '0;
    logic [NCH-1:0]    in_valid = '0;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     out_ch;
    logic [7:0]        out_seq;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [NCH-1:0]    overflow;
    logic              ovf_clr = 1'b0;

    int tests = 0;
    int failed = 0;

    always #5 clk = ~clk;

    decim_readout_arbiter #(.NCH(NCH), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .out_data  (out_data),
        .out_ch    (out_ch),
        .out_seq   (out_seq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overflow  (overflow),
        .ovf_clr   (ovf_clr)
    );

    // Reference model state
    bit            m_full [NCH];
    logic [DW-1:0] m_hd   [NCH];
    int            m_hs   [NCH];
    int            m_seq  [NCH];
    bit            m_ovf  [NCH];
    int            m_rr;
    bit            m_ov;
    logic [DW-1:0] m_od;
    int            m_och, m_oseq;

    function automatic void model_step();
        int  g;
        bit  fr;
        if (!rst_n) begin
            for (int i = 0; i < NCH; i++) begin
                m_full[i] = 0; m_hd[i] = '0; m_hs[i] = 0; m_seq[i] = 0; m_ovf[i] = 0;
            end
            m_rr = 0; m_ov = 0; m_od = '0; m_och = 0; m_oseq = 0;
            return;
        end
        fr = !m_ov || out_ready;
        g  = -1;
        if (fr) begin
            for (int k = 0; k < NCH; k++) begin
                int c = (m_rr + k) % NCH;
                if (g < 0 && m_full[c]) g = c;
            end
        end
        // pop first: the granted slot becomes free before this cycle's captures land
        if (g >= 0) begin
            m_od = m_hd[g]; m_och = g; m_oseq = m_hs[g];
            m_ov = 1; m_rr = (g + 1) % NCH; m_full[g] = 0;
        end else if (fr) begin
            m_ov = 0;
        end
        if (ovf_clr) for (int i = 0; i < NCH; i++) m_ovf[i] = 0;
        for (int i = 0; i < NCH; i++) begin
            if (en && in_valid[i]) begin
                if (!m_full[i]) begin
                    m_hd[i] = in_data[i*DW +: DW]; m_hs[i] = m_seq[i]; m_full[i] = 1;
                end else begin
                    m_ovf[i] = 1;
                end
                m_seq[i] = (m_seq[i] + 1) % 256;
            end
        end
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [NCH-1:0] v;
        for (int i = 0; i < NCH; i++) v[i] = m_ovf[i];
        chk("model_valid", 32'(out_valid), 32'(m_ov));
        if (m_ov) begin
            chk("model_data", 32'(out_data), 32'(m_od));
            chk("model_ch",   32'(out_ch),   32'(m_och));
            chk("model_seq",  32'(out_seq),  32'(m_oseq));
        end
        chk("model_ovf", 32'(overflow), 32'(v));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic cycles(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_data(input int ch, input logic [DW-1:0] d);
        in_data[ch*DW +: DW] = d;
    endtask

    task automatic pulse(input logic [NCH-1:0] mask);
        in_valid = mask;
        cycle();
        in_valid = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; in_valid = '0; ovf_clr = 1'b0; out_ready = 1'b0;
        cycles(2);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        do_reset();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_ch",    32'(out_ch),    0);
        chk("rst_seq",   32'(out_seq),   0);
        chk("rst_ovf",   32'(overflow),  0);

        // single sample, two-cycle latency
        en = 1; out_ready = 1;
        set_data(0, 27'h1234567);
        pulse(4'b0001);
        chk("single_c1_valid", 32'(out_valid), 0);
        cycle();
        chk("single_valid", 32'(out_valid), 1);
        chk("single_data",  32'(out_data),  32'h1234567);
        chk("single_ch",    32'(out_ch),    0);
        chk("single_seq",   32'(out_seq),   0);
        cycle();
        chk("single_drop", 32'(out_valid), 0);

        // round-robin fairness from rr=0
        do_reset();
        en = 1; out_ready = 1;
        for (int i = 0; i < NCH; i++) set_data(i, DW'(i + 1));
        pulse(4'b1111);
        cycle();
        for (int k = 0; k < NCH; k++) begin
            chk("rr_ch",   32'(out_ch),   32'(k));
            chk("rr_data", 32'(out_data), 32'(k + 1));
            cycle();
        end
        chk("rr_idle", 32'(out_valid), 0);
        for (int i = 0; i < NCH; i++) set_data(i, DW'(8'h10 + i));
        pulse(4'b1111);
        cycle();
        chk("rr2_ch",  32'(out_ch),  0);
        chk("rr2_seq", 32'(out_seq), 1);

        // back-pressure and overflow on ch2
        do_reset();
        en = 1; out_ready = 0;
        set_data(2, 27'h0AAAAAA); pulse(4'b0100); cycles(511);
        set_data(2, 27'h0BBBBBB); pulse(4'b0100); cycles(511);
        set_data(2, 27'h0CCCCCC); pulse(4'b0100); cycles(3);
        chk("bp_valid", 32'(out_valid), 1);
        chk("bp_data",  32'(out_data),  32'h0AAAAAA);
        chk("bp_seq",   32'(out_seq),   0);
        chk("bp_ovf",   32'(overflow),  32'h4);
        out_ready = 1;
        cycle();
        chk("bp_b_data", 32'(out_data), 32'h0BBBBBB);
        chk("bp_b_seq",  32'(out_seq),  1);
        cycle();
        chk("bp_empty", 32'(out_valid), 0);
        set_data(2, 27'h0DDDDDD); pulse(4'b0100); cycle();
        chk("bp_d_seq",  32'(out_seq),  3);
        chk("bp_d_data", 32'(out_data), 32'h0DDDDDD);

        // same-cycle pop and push on ch1
        do_reset();
        en = 1; out_ready = 0;
        set_data(0, 27'h111); pulse(4'b0001); cycle();
        set_data(1, 27'h222); pulse(4'b0010); cycle();
        out_ready = 1;
        set_data(1, 27'h333); pulse(4'b0010);
        chk("pp_old_data", 32'(out_data), 32'h222);
        chk("pp_old_ch",   32'(out_ch),   1);
        chk("pp_ovf",      32'(overflow), 0);
        cycle();
        chk("pp_new_data", 32'(out_data), 32'h333);
        chk("pp_new_seq",  32'(out_seq),  1);

        // ovf_clr coinciding with a drop: set wins
        do_reset();
        en = 1; out_ready = 0;
        pulse(4'b1000); cycle();
        pulse(4'b1000); cycle();
        ovf_clr = 1; pulse(4'b1000); ovf_clr = 0;
        chk("clr_setwins", 32'(overflow), 32'h8);
        ovf_clr = 1; cycle(); ovf_clr = 0;
        chk("clr_clean", 32'(overflow), 0);

        // reset mid-transfer, then enable gating
        do_reset();
        en = 1; out_ready = 0;
        pulse(4'b0001); cycle();
        pulse(4'b0110); cycle();
        chk("midrst_pre", 32'(out_valid), 1);
        rst_n = 0; cycle();
        chk("midrst_valid", 32'(out_valid), 0);
        chk("midrst_data",  32'(out_data),  0);
        chk("midrst_ch",    32'(out_ch),    0);
        chk("midrst_seq",   32'(out_seq),   0);
        chk("midrst_ovf",   32'(overflow),  0);
        rst_n = 1; out_ready = 1; cycles(3);
        chk("midrst_drained", 32'(out_valid), 0);
        en = 0;
        in_valid = 4'b1111; cycles(3); in_valid = '0; cycles(3);
        chk("en_off", 32'(out_valid), 0);
        en = 1;
        set_data(1, 27'h5A5A5A5); pulse(4'b0010); cycle();
        chk("en_on_ch",  32'(out_ch),  1);
        chk("en_on_seq", 32'(out_seq), 0);

        // randomized traffic, model compared every cycle
        do_reset();
        for (int blk = 0; blk < 8; blk++) begin
            int rdy_pct = (blk % 2 == 0) ? 85 : 25;
            int iv_pct  = 10 + 10 * (blk % 4);
            for (int n = 0; n < 500; n++) begin
                rst_n   = ($urandom_range(0, 599) != 0);
                en      = ($urandom_range(0, 7) != 0);
                ovf_clr = ($urandom_range(0, 31) == 0);
                out_ready = ($urandom_range(0, 99) < rdy_pct);
                for (int i = 0; i < NCH; i++) begin
                    in_valid[i] = ($urandom_range(0, 99) < iv_pct);
                    set_data(i, DW'($urandom));
                end
                cycle();
            end
        end
        rst_n = 1; in_valid = '0; ovf_clr = 0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
